// File: rtl/block_map_expand.sv
// block_map_expand: double-buffered block bitmap re-expanded over the live pixel stream.
module block_map_expand #(
    parameter int P_W    = 12,
    parameter int IMG_X  = 640,
    parameter int IMG_Y  = 480,
    parameter int CS     = 8,
    parameter int CL     = 40,
    parameter int CR     = 30,
    parameter int WIN_X1 = 160,
    parameter int WIN_Y1 = 120
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i_blk_valid,
    input  logic        i_blk_wb,
    input  logic        i_pix_valid,
    input  logic [15:0] i_pix_data,
    output logic        o_pix_valid,
    output logic [15:0] o_pix_data,
    output logic        o_map_ok,
    output logic        o_frame_done
);
    localparam int PXW = $clog2(CS);
    localparam int BXW = $clog2(CL);
    localparam int BYW = $clog2(CR);
    localparam logic [P_W-1:0] X_LO  = P_W'(WIN_X1);
    localparam logic [P_W-1:0] X_HI  = P_W'(WIN_X1 + CL * CS - 1);
    localparam logic [P_W-1:0] Y_LO  = P_W'(WIN_Y1);
    localparam logic [P_W-1:0] Y_HI  = P_W'(WIN_Y1 + CR * CS - 1);
    localparam logic [P_W-1:0] X_END = P_W'(IMG_X - 1);
    localparam logic [P_W-1:0] Y_END = P_W'(IMG_Y - 1);

    logic map_mem [2][CR][CL];

    logic [BXW-1:0] wr_col_q, wr_col_d, bx_q, bx_d;
    logic [BYW-1:0] wr_row_q, wr_row_d, by_q, by_d;
    logic [PXW-1:0] px_q, px_d, py_q, py_d;
    logic [P_W-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic [15:0]    pix_data_q, pix_data_d;
    logic wr_bank_q, wr_bank_d, done_bank_q, done_bank_d, rd_bank_q, rd_bank_d;
    logic map_ok_q, map_ok_d, frame_done_q, frame_done_d, pix_valid_q, pix_valid_d;
    logic col_end, last_wr, frame_start, in_win, line_end, x_end;

    always_comb begin
        col_end      = wr_col_q == BXW'(CL - 1);
        last_wr      = i_blk_valid && col_end && wr_row_q == BYW'(CR - 1);
        wr_col_d     = !i_blk_valid ? wr_col_q : col_end ? '0 : wr_col_q + 1'b1;
        wr_row_d     = !(i_blk_valid && col_end) ? wr_row_q : last_wr ? '0 : wr_row_q + 1'b1;
        wr_bank_d    = wr_bank_q ^ last_wr;
        done_bank_d  = last_wr ? wr_bank_q : done_bank_q;
        map_ok_d     = map_ok_q | last_wr;
        frame_done_d = last_wr;
        frame_start  = i_pix_valid && cnt_x_q == '0 && cnt_y_q == '0;
        // a frame completing on the frame-start cycle is handed to the reader directly
        rd_bank_d    = !frame_start ? rd_bank_q : last_wr ? wr_bank_q : done_bank_q;
        x_end        = cnt_x_q == X_END;
        cnt_x_d      = !i_pix_valid ? cnt_x_q : x_end ? '0 : cnt_x_q + 1'b1;
        cnt_y_d      = !(i_pix_valid && x_end) ? cnt_y_q : cnt_y_q == Y_END ? '0 : cnt_y_q + 1'b1;
        in_win       = i_pix_valid && cnt_x_q >= X_LO && cnt_x_q <= X_HI &&
                       cnt_y_q >= Y_LO && cnt_y_q <= Y_HI;
        line_end     = in_win && cnt_x_q == X_HI;
        px_d = frame_start ? '0 : !in_win ? px_q : px_q == PXW'(CS - 1) ? '0 : px_q + 1'b1;
        bx_d = frame_start ? '0 : !(in_win && px_q == PXW'(CS - 1)) ? bx_q :
               bx_q == BXW'(CL - 1) ? '0 : bx_q + 1'b1;
        py_d = frame_start ? '0 : !line_end ? py_q : py_q == PXW'(CS - 1) ? '0 : py_q + 1'b1;
        by_d = frame_start ? '0 : !(line_end && py_q == PXW'(CS - 1)) ? by_q :
               by_q == BYW'(CR - 1) ? '0 : by_q + 1'b1;
        pix_valid_d  = i_pix_valid;
        pix_data_d   = !i_pix_valid ? '0 :
                       (in_win && map_ok_q) ? {16{map_mem[rd_bank_q][by_q][bx_q]}} : i_pix_data;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && i_blk_valid)
            map_mem[wr_bank_q][wr_row_q][wr_col_q] <= i_blk_wb;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_col_q     <= '0;
            wr_row_q     <= '0;
            wr_bank_q    <= 1'b0;
            done_bank_q  <= 1'b0;
            rd_bank_q    <= 1'b0;
            map_ok_q     <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_x_q      <= '0;
            cnt_y_q      <= '0;
            px_q         <= '0;
            bx_q         <= '0;
            py_q         <= '0;
            by_q         <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
        end else begin
            wr_col_q     <= wr_col_d;
            wr_row_q     <= wr_row_d;
            wr_bank_q    <= wr_bank_d;
            done_bank_q  <= done_bank_d;
            rd_bank_q    <= rd_bank_d;
            map_ok_q     <= map_ok_d;
            frame_done_q <= frame_done_d;
            cnt_x_q      <= cnt_x_d;
            cnt_y_q      <= cnt_y_d;
            px_q         <= px_d;
            bx_q         <= bx_d;
            py_q         <= py_d;
            by_q         <= by_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
        end
    end

    assign o_pix_valid  = pix_valid_q;
    assign o_pix_data   = pix_data_q;
    assign o_map_ok     = map_ok_q;
    assign o_frame_done = frame_done_q;
endmodule

// File: tb/tb_block_map_expand.sv
// tb_block_map_expand: directed and mixed stimulus against a linear-index frame model.
module tb_block_map_expand;
    localparam int IX = 64, IY = 48, CSZ = 4, NCL = 8, NCR = 6, WX = 16, WY = 12;
    localparam int FRAME = IX * IY, NB = NCL * NCR;

    logic        clk, sys_rst, i_blk_valid, i_blk_wb, i_pix_valid;
    logic [15:0] i_pix_data, o_pix_data;
    logic        o_pix_valid, o_map_ok, o_frame_done;

    block_map_expand #(
        .P_W(12), .IMG_X(IX), .IMG_Y(IY), .CS(CSZ), .CL(NCL), .CR(NCR), .WIN_X1(WX), .WIN_Y1(WY)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .i_blk_valid(i_blk_valid), .i_blk_wb(i_blk_wb),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_valid(o_pix_valid),
        .o_pix_data(o_pix_data), .o_map_ok(o_map_ok), .o_frame_done(o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0, fd_cnt = 0;
    int n_blk = 0, n_pix = 0, rd_m = 0, exp_pos = 0;
    bit ok_m = 0;
    bit mm [2][NB];
    logic [15:0] cap [FRAME];
    logic exp_en = 1'b0, exp_v, exp_ok, exp_fd;
    logic [15:0] exp_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, req, $time);
    endtask

    // drive one cycle and derive the expected outputs from block/pixel counts
    task automatic step(input logic r, input logic bv, input logic bw, input logic pv,
                        input logic [15:0] pd);
        int p, x, y, fr, bi;
        logic last, inw;
        @(negedge clk);
        sys_rst = r; i_blk_valid = bv; i_blk_wb = bw; i_pix_valid = pv; i_pix_data = pd;
        if (r) begin
            exp_v = 0; exp_d = 0; exp_ok = 0; exp_fd = 0;
            n_blk = 0; n_pix = 0; rd_m = 0; ok_m = 0;
        end else begin
            p = n_pix % FRAME; x = p % IX; y = p / IX;
            last = bv && (n_blk % NB == NB - 1);
            fr = (n_blk + (last ? 1 : 0)) / NB;
            if (pv && p == 0) rd_m = (fr == 0) ? 0 : (fr - 1) % 2;
            inw = x >= WX && x < WX + NCL * CSZ && y >= WY && y < WY + NCR * CSZ;
            bi = inw ? ((y - WY) / CSZ) * NCL + (x - WX) / CSZ : 0;
            exp_v = pv; exp_pos = p;
            exp_d = !pv ? 16'h0 : (inw && ok_m) ? (mm[rd_m][bi] ? 16'hFFFF : 16'h0000) : pd;
            if (bv) begin
                mm[(n_blk / NB) % 2][n_blk % NB] = bw;
                n_blk++;
            end
            ok_m = ok_m | last; exp_ok = ok_m; exp_fd = last;
            if (pv) n_pix++;
        end
        exp_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_en) begin
            chk("pix_valid", o_pix_valid, exp_v);
            chk("pix_data", o_pix_data, exp_d);
            chk("map_ok", o_map_ok, exp_ok);
            chk("frame_done", o_frame_done, exp_fd);
            if (o_frame_done) fd_cnt++;
            if (exp_v) cap[exp_pos] = o_pix_data;
        end
    end

    int nb;
    logic b6, p6;
    initial begin
        sys_rst = 1; i_blk_valid = 0; i_blk_wb = 0; i_pix_valid = 0; i_pix_data = 0;
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);

        for (int i = 0; i < FRAME; i++) step(0, 0, 0, 1, 16'h1234);
        idle(1);
        chk("t1_map_ok", o_map_ok, 0);
        chk("t1_win_pass", cap[WY * IX + WX], 16'h1234);

        fd_cnt = 0;
        for (int r = 0; r < NCR; r++)
            for (int c = 0; c < NCL; c++) step(0, 1, logic'((r + c) % 2), 0, 16'h0);
        idle(2);
        chk("t2_fd_once", fd_cnt, 1);
        chk("t2_map_ok", o_map_ok, 1);
        for (int i = 0; i < FRAME; i++) step(0, 0, 0, 1, 16'h1234);
        idle(1);
        chk("t2_first_blk", cap[WY * IX + WX], 16'h0000);
        chk("t2_second_blk", cap[WY * IX + WX + CSZ], 16'hFFFF);
        chk("t2_row1_blk", cap[(WY + CSZ) * IX + WX], 16'hFFFF);
        chk("t2_left_out", cap[WY * IX + WX - 1], 16'h1234);
        chk("t2_right_out", cap[20 * IX + 48], 16'h1234);

        for (int i = 0; i < NB; i++) step(0, 1, 1, 0, 16'h0);
        nb = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(0, (i % 20 == 0 && nb < NB), 0, 1, 16'h5A5A);
            if (i % 20 == 0 && nb < NB) nb++;
        end
        idle(1);
        chk("t3_win_start", cap[WY * IX + WX], 16'hFFFF);
        chk("t3_win_end", cap[35 * IX + 47], 16'hFFFF);
        for (int i = 0; i < FRAME; i++) step(0, 0, 0, 1, 16'h5A5A);
        idle(1);
        chk("t3_next_frame", cap[WY * IX + WX], 16'h0000);

        for (int i = 0; i < NB - 1; i++) step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 1, 16'h7777);
        for (int i = 1; i < FRAME; i++) step(0, 0, 0, 1, 16'h7777);
        idle(1);
        chk("t4_bypass_win", cap[WY * IX + WX], 16'hFFFF);
        chk("t4_origin", cap[0], 16'h7777);

        for (int i = 0; i < NB / 2; i++) step(0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 16'h1111);
        step(1, 1, 1, 1, 16'h1111);
        @(posedge clk); #2;
        chk("t5_rst_data", o_pix_data, 0);
        chk("t5_rst_valid", o_pix_valid, 0);
        chk("t5_rst_ok", o_map_ok, 0);
        for (int i = 0; i < FRAME; i++) step(0, 0, 0, 1, 16'(i));
        idle(1);
        chk("t5_pass_win", cap[WY * IX + WX], 16'(WY * IX + WX));

        for (int ph = 0; ph < 3; ph++)
            for (int c = 0; c < 4000; c++) begin
                b6 = (ph == 0) ? (c % 2 == 0) : (ph == 1) ? 1'b1 : logic'($urandom_range(0, 1));
                p6 = (ph == 0) ? (c % 2 == 1) : (ph == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                step(0, b6, logic'($urandom_range(0, 1)), p6, 16'($urandom));
            end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/block_map_expand.md
Name: block_map_expand

Overview:
- Receiving end of the per-block black/white stream produced by the corrosion stage, which emits one bit per CS x CS block in raster order.
- Stores a full frame of block bits in a double-buffered bitmap.
- Re-expands the stored bits onto the live OV5640 pixel stream: every pixel in the processing window is replaced by its block's colour; pixels outside the window pass through unchanged.
- Feeds the display path, so the corroded result is visible at full resolution.

Parameters:
P_W, 12, width of pixel position counters
IMG_X, 640, pixels per line
IMG_Y, 480, lines per frame
CS, 8, block edge in pixels
CL, 40, blocks per block-row
CR, 30, block-rows per frame
WIN_X1, 160, first window column (window spans WIN_X1..WIN_X1+CL*CS-1)
WIN_Y1, 120, first window line (window spans WIN_Y1..WIN_Y1+CR*CS-1)

Ports:
sys_clk  in  1  single clock for both sides
sys_rst  in  1  synchronous, active-high reset
i_blk_valid  in  1  one block bit present this cycle
i_blk_wb  in  1  block bit: 1 = white, 0 = black
i_pix_valid  in  1  live pixel present this cycle
i_pix_data  in  16  live RGB565 pixel
o_pix_valid  out  1  registered copy of i_pix_valid
o_pix_data  out  16  overlaid pixel
o_map_ok  out  1  at least one complete block frame is stored
o_frame_done  out  1  one-cycle pulse: a block frame was just completed

Behaviour:
- Reset: all outputs 0, all counters 0, wr_bank=0, rd_bank=0, map_ok=0. Bitmap contents need not be cleared.
- Storage: bitmap of 2 banks x CR x CL bits. Flops or distributed RAM; any read latency must be hidden inside the fixed output latency.

Write side:
- Counters wr_col (0..CL-1) and wr_row (0..CR-1).
- On i_blk_valid: write i_blk_wb to bank wr_bank at (wr_row, wr_col).
- wr_col increments; at CL-1 it wraps to 0 and wr_row increments.
- At (CR-1, CL-1): wr_row wraps to 0, wr_bank toggles, done_bank takes the bank just written, map_ok is set.
- o_frame_done pulses on the cycle after that last write.
- Without i_blk_valid, all write-side state holds.

Read side:
- Counters cnt_x (0..IMG_X-1) and cnt_y (0..IMG_Y-1) advance only on i_pix_valid, in raster order.
  - cnt_x wraps at IMG_X-1 and increments cnt_y.
  - cnt_y wraps at IMG_Y-1.
- Block position inside the window uses sub-counters, not division:
  - px (0..CS-1) and bx (0..CL-1) advance with in-window pixels.
  - py (0..CS-1) and by (0..CR-1) advance at the last in-window pixel of each window line.
  - All four reset to 0 at frame start.
- Frame start is an i_pix_valid pixel with cnt_x==0 and cnt_y==0. At frame start rd_bank loads done_bank.
  - Bypass: if the last block write completes on the same cycle, rd_bank takes the newly completed bank.
  - rd_bank is stable for the rest of the frame, so no tearing occurs.

Output (latency exactly 1 cycle from i_pix_valid/i_pix_data):
- o_pix_valid <= i_pix_valid.
- Pixel in window and map_ok=1: o_pix_data <= 16'hFFFF if the bit at (by, bx) in rd_bank is 1, else 16'h0000.
- Pixel outside the window, or map_ok=0: o_pix_data <= i_pix_data.
- When i_pix_valid=0: o_pix_data <= 0.

Boundaries:
- The two sides are independent. Simultaneous i_blk_valid and i_pix_valid are both serviced in the same cycle.
- A write to wr_bank never disturbs rd_bank while the two banks differ.
- If the writer completes two frames within one read frame, rd_bank takes the latest complete bank at the next frame start.
- Reset mid-frame: both sides restart at position 0 and map_ok=0, so output returns to pass-through until a full block frame is rewritten.

Test Plan:
1. Reset, then a 640x480 pixel frame with i_pix_data=16'h1234 and no blocks -> every output pixel is 16'h1234 one cycle later, o_map_ok=0.
2. Write 1200 blocks with bit = (bx+by) odd, then one pixel frame -> pixel (160,120)=16'h0000, pixel (168,120)=16'hFFFF, pixel (159,120)=input, pixel (480,200)=input; o_frame_done pulses exactly once, one cycle after block 1200.
3. Write an all-ones block frame, then an all-zeros block frame that completes mid pixel-frame -> the rest of that pixel frame stays 16'hFFFF in the window; the next pixel frame shows 16'h0000.
4. Last block write on the same cycle as the pixel at (0,0) -> that pixel frame already uses the new bank.
5. Assert sys_rst after 600 blocks and mid-line -> outputs 0 on the next cycle, o_map_ok=0; the following pixel frame is pure pass-through.
6. Interleave i_blk_valid and i_pix_valid on alternate cycles and on the same cycles with random stalls -> output matches a reference model bit-exactly; o_pix_valid always equals i_pix_valid delayed by one cycle.
